// File: rtl/fetch_queue.sv
// fetch_queue: decoupled fetch unit owning the fetch PC, the icache request FSM and an
// instruction/PC FIFO popped by ID. Define FETCH_PERF_EN to add saturating perf counters.
module fetch_queue #(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h00000060
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   icache_read,
  output logic [XLEN-1:0]        icache_addr,
  input  logic [31:0]            icache_rdata,
  input  logic                   icache_resp,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   deq_ready,
  output logic                   deq_valid,
  output logic [31:0]            deq_instr,
  output logic [XLEN-1:0]        deq_pc,
  output logic [$clog2(DEPTH):0] occupancy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_dropped,
  output logic [31:0]            perf_full_cycles
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [CW-1:0]   count_q, count_d, count_nx;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [XLEN+31:0] mem_q [DEPTH];
  logic [XLEN+31:0] head;
  logic            push, pop;

  always_comb begin
    push       = (state_q == S_REQ) && icache_resp && !redirect;
    pop        = (count_q != '0) && deq_ready && !redirect;
    count_nx   = count_q + CW'(push) - CW'(pop);
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_nx;
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    if (push) fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc & ~XLEN'(1);
    end
    unique case (state_q)
      S_IDLE: if (redirect || (count_nx < CW'(DEPTH))) state_d = S_REQ;
      // Redirect with the request still outstanding: keep the old address on the
      // bus until the icache answers, then throw that answer away.
      S_REQ: begin
        if (redirect && !icache_resp) begin
          req_pc_d = fetch_pc_q;
          state_d  = S_DROP;
        end else if (push && (count_nx >= CW'(DEPTH))) begin
          state_d = S_IDLE;
        end
      end
      S_DROP: if (icache_resp) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {fetch_pc_q, icache_rdata};
  end

  assign head        = mem_q[rd_ptr_q];
  assign icache_read = (state_q == S_REQ) || (state_q == S_DROP);
  assign icache_addr = (state_q == S_DROP) ? req_pc_q : fetch_pc_q;
  assign deq_valid   = (count_q != '0);
  assign deq_instr   = head[31:0];
  assign deq_pc      = head[XLEN+31:32];
  assign occupancy   = count_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;
  logic [31:0] perf_full_q, perf_full_d;
  logic        drop_ev;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  always_comb begin
    drop_ev        = icache_resp && ((state_q == S_DROP) || ((state_q == S_REQ) && redirect));
    perf_fetched_d = sat_inc(perf_fetched_q, push);
    perf_dropped_d = sat_inc(perf_dropped_q, drop_ev);
    perf_full_d    = sat_inc(perf_full_q, (state_q == S_IDLE) && !redirect);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
      perf_full_q    <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
      perf_full_q    <= perf_full_d;
    end
  end

  assign perf_fetched     = perf_fetched_q;
  assign perf_dropped     = perf_dropped_q;
  assign perf_full_cycles = perf_full_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the bench plays the icache, keeps an abstract model of
// the fetch stream (next PC, pending stale request, expected queue contents) and checks ID pops.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        icache_read;
  logic [31:0] icache_addr;
  logic [31:0] icache_rdata = '0;
  logic        icache_resp = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        deq_ready = 1'b0;
  logic        deq_valid;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .RESET_PC(32'h00000060)) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_addr(icache_addr),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_instr(deq_instr), .deq_pc(deq_pc), .occupancy(occupancy)
  );

  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ent_t;

  ent_t        sb[$];
  ent_t        mon_e;
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_pc, stale_addr;
  bit          stale;
  bit          p_read, p_resp, p_redir;
  logic [31:0] p_rpc, p_addr, p_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    model_pc = 32'h60;
    stale = 0; stale_addr = '0;
    p_read = 0; p_resp = 0; p_redir = 0;
    p_rpc = '0; p_addr = '0; p_data = '0;
  endtask

  // Advance one clock, fold last cycle's transfer into the model, check the request side.
  task automatic tick();
    @(posedge clk);
    #1;
    if (p_redir) begin
      sb.delete();
      model_pc = p_rpc & ~32'h1;
      stale = p_read && !p_resp;
      if (stale) stale_addr = p_addr;
    end else if (p_read && p_resp) begin
      if (stale) stale = 0;
      else begin
        sb.push_back('{pc: model_pc, instr: p_data});
        model_pc += 32'd4;
      end
    end
    if (icache_read) begin
      chk("req_addr", icache_addr, stale ? stale_addr : model_pc);
      if (!stale) chk("req_room", sb.size() < DEPTH, 1);
    end else begin
      chk("idle_only_full", sb.size(), DEPTH);
    end
  endtask

  task automatic drive(input bit resp, input bit redir, input logic [31:0] rpc,
                       input bit rdy, input bit rnd);
    icache_resp  = resp && icache_read;
    icache_rdata = rnd ? $urandom : icache_addr;
    redirect     = redir;
    redirect_pc  = rpc;
    deq_ready    = rdy;
    p_read = icache_read; p_resp = icache_resp; p_redir = redir;
    p_rpc = rpc; p_addr = icache_addr; p_data = icache_rdata;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    icache_resp = 0; redirect = 0; redirect_pc = '0; deq_ready = 0; icache_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read", icache_read, 0);
    chk("rst_addr", icache_addr, 32'h60);
    chk("rst_occ", occupancy, 0);
    chk("rst_valid", deq_valid, 0);
    rst = 1'b1;
  endtask

  // Monitor: checks occupancy/valid against the model and pops on every ID transfer.
  always @(negedge clk) begin
    if (rst) begin
      chk("occupancy", occupancy, sb.size());
      chk("deq_valid", deq_valid, sb.size() != 0);
      if (deq_valid && deq_ready && !redirect && sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("deq_pc", deq_pc, mon_e.pc);
        chk("deq_instr", deq_instr, mon_e.instr);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Streaming at one instruction per cycle.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i >= 1) begin
        chk("t1_valid", deq_valid, 1);
        chk("t1_pc", deq_pc, 32'h60 + 32'(4 * (i - 1)));
        chk("t1_instr", deq_instr, 32'h60 + 32'(4 * (i - 1)));
      end
      drive(1, 0, '0, 1, 0);
    end

    // Fill to DEPTH with ID stalled, then drain.
    do_reset();
    for (int i = 0; i < 6; i++) begin tick(); drive(1, 0, '0, 0, 0); end
    chk("t2_occ_full", occupancy, 4);
    chk("t2_read_off", icache_read, 0);
    drive(1, 0, '0, 1, 0);
    tick();
    chk("t2_resume_read", icache_read, 1);
    chk("t2_resume_addr", icache_addr, 32'h70);
    chk("t2_head", deq_pc, 32'h64);
    for (int i = 0; i < 6; i++) begin drive(1, 0, '0, 1, 0); tick(); end

    // Redirect while full and idle.
    do_reset();
    for (int i = 0; i < 6; i++) begin tick(); drive(1, 0, '0, 0, 0); end
    drive(0, 1, 32'h200, 0, 0);
    tick();
    chk("t3_occ", occupancy, 0);
    chk("t3_valid", deq_valid, 0);
    chk("t3_addr", icache_addr, 32'h200);
    chk("t3_read", icache_read, 1);

    // Redirect while the 0x70 request is outstanding; its data must be dropped.
    do_reset();
    tick();
    n = 0;
    while (icache_addr != 32'h70 && n < 20) begin drive(1, 0, '0, 1, 0); tick(); n++; end
    chk("t4_reach70", icache_addr, 32'h70);
    drive(0, 1, 32'h200, 1, 0);
    tick(); chk("t4_hold1", icache_addr, 32'h70); chk("t4_read1", icache_read, 1);
    drive(0, 0, '0, 1, 0);
    tick(); chk("t4_hold2", icache_addr, 32'h70);
    drive(1, 0, '0, 1, 0);
    tick(); chk("t4_new_addr", icache_addr, 32'h200);
    drive(1, 0, '0, 1, 0);
    tick(); chk("t4_first_valid", deq_valid, 1); chk("t4_first_pc", deq_pc, 32'h200);
    drive(0, 0, '0, 1, 0);

    // Redirect coincident with the response for 0x64.
    do_reset();
    tick();
    n = 0;
    while (icache_addr != 32'h64 && n < 20) begin drive(1, 0, '0, 0, 0); tick(); n++; end
    chk("t5_reach64", icache_addr, 32'h64);
    drive(1, 1, 32'h300, 1, 0);
    tick();
    chk("t5_addr", icache_addr, 32'h300);
    chk("t5_read", icache_read, 1);
    for (int i = 0; i < 4; i++) begin drive(1, 0, '0, 1, 0); tick(); end

    // Asynchronous reset while waiting out a dropped response.
    do_reset();
    tick(); drive(1, 0, '0, 0, 0);
    tick(); drive(1, 0, '0, 0, 0);
    tick(); drive(0, 1, 32'h400, 0, 0);
    tick();
    chk("t6_drop_addr", icache_addr, 32'h68);
    drive(0, 0, '0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_read", icache_read, 0);
    chk("t6_async_occ", occupancy, 0);
    chk("t6_async_addr", icache_addr, 32'h60);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    chk("t6_restart_read", icache_read, 1);
    chk("t6_restart_addr", icache_addr, 32'h60);

    // Randomized traffic: variable icache latency, random redirects (odd targets included).
    drive(0, 0, '0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      tick();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom,
            $urandom_range(0, 9) < 6, 1);
    end
    tick();
    drive(0, 0, '0, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
